// File: rtl/dmem_ctrl.sv
// Data-memory controller for the MEM stage of the pipelined core.
// Handles one load/store per cycle, steers bytes by the low address bits,
// rejects bad requests with an error response, and extends load data.
// Read data is registered for one-cycle latency. A single response
// register holds the result while downstream stalls.
module dmem_ctrl #(
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_type,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [15:0]           err_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-3:0] DEPTH_L = (ADDR_WIDTH-2)'(DEPTH);

    localparam logic [2:0] T_WORD = 3'd0;
    localparam logic [2:0] T_HALF = 3'd1;
    localparam logic [2:0] T_HALFU = 3'd2;
    localparam logic [2:0] T_BYTE = 3'd3;
    localparam logic [2:0] T_BYTEU = 3'd4;

    logic [31:0] mem [DEPTH];

    logic [1:0]            off;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [IDX_W-1:0]      mem_idx;
    logic                  accept;
    logic                  req_bad;
    logic [3:0]            lane_en;
    logic [31:0]           lane_data;

    logic [31:0] raw_q;
    logic [2:0]  type_q;
    logic [1:0]  off_q;
    logic        load_q;
    logic [31:0] ext_data;

    assign off       = req_addr[1:0];
    assign word_idx  = req_addr[ADDR_WIDTH-1:2];
    assign mem_idx   = word_idx[IDX_W-1:0];
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    // Reject illegal types, misaligned accesses and out-of-range word indices.
    always_comb begin
        req_bad = 1'b0;
        case (req_type)
            T_WORD:          req_bad = (off != 2'd0);
            T_HALF, T_HALFU: req_bad = off[0];
            T_BYTE, T_BYTEU: req_bad = 1'b0;
            default:         req_bad = 1'b1;
        endcase
        if (word_idx >= DEPTH_L) begin
            req_bad = 1'b1;
        end
    end

    // Byte-lane enables and replicated store data for the access size.
    always_comb begin
        lane_en   = 4'b1111;
        lane_data = req_wdata;
        case (req_type)
            T_HALF, T_HALFU: begin
                lane_en   = off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{req_wdata[15:0]}};
            end
            T_BYTE, T_BYTEU: begin
                lane_en   = 4'b0001 << off;
                lane_data = {4{req_wdata[7:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                lane_data = req_wdata;
            end
        endcase
    end

    // Store commit at the accept edge; suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_bad && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[mem_idx][i*8 +: 8] <= lane_data[i*8 +: 8];
                end
            end
        end
    end

    // Response register, captured load word and saturating error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            load_q    <= 1'b0;
            raw_q     <= 32'd0;
            type_q    <= 3'd0;
            off_q     <= 2'd0;
            err_count <= 16'd0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= req_bad;
            load_q    <= !req_we && !req_bad;
            type_q    <= req_type;
            off_q     <= off;
            if (!req_we && !req_bad) begin
                raw_q <= mem[mem_idx];
            end
            if (req_bad && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Lane extraction and sign/zero extension from the captured word.
    always_comb begin
        ext_data = raw_q;
        case (type_q)
            T_HALF:  ext_data = off_q[1] ? {{16{raw_q[31]}}, raw_q[31:16]}
                                         : {{16{raw_q[15]}}, raw_q[15:0]};
            T_HALFU: ext_data = off_q[1] ? {16'd0, raw_q[31:16]}
                                         : {16'd0, raw_q[15:0]};
            T_BYTE:  ext_data = {{24{raw_q[off_q*8+7]}}, raw_q[off_q*8 +: 8]};
            T_BYTEU: ext_data = {24'd0, raw_q[off_q*8 +: 8]};
            default: ext_data = raw_q;
        endcase
    end

    // Stores and rejected requests return zero data.
    assign rsp_rdata = load_q ? ext_data : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a vector table for the single-beat
// requests plus hand-written backpressure and mid-operation reset sequences.
module tb_dmem_ctrl;

    localparam int DEPTH = 2048;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_type;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [15:0]   err_count;

    int total = 0;
    int bad   = 0;

    dmem_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_type  = typ;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_type  = 3'd0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        vecs[0]  = '{1'b1, 3'd0, 32'h10, 32'h800000F0, 32'h0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 3'd3, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 3'd4, 32'h13, 32'h0, 32'h00000080, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF8000, 1'b0, 16'd0};
        vecs[4]  = '{1'b0, 3'd2, 32'h10, 32'h0, 32'h000000F0, 1'b0, 16'd0};
        vecs[5]  = '{1'b1, 3'd3, 32'h11, 32'h0000005A, 32'h0, 1'b0, 16'd0};
        vecs[6]  = '{1'b0, 3'd0, 32'h10, 32'h0, 32'h80005AF0, 1'b0, 16'd0};
        vecs[7]  = '{1'b1, 3'd1, 32'h12, 32'h00001234, 32'h0, 1'b0, 16'd0};
        vecs[8]  = '{1'b0, 3'd0, 32'h10, 32'h0, 32'h12345AF0, 1'b0, 16'd0};
        vecs[9]  = '{1'b1, 3'd0, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1, 16'd1};
        vecs[10] = '{1'b0, 3'd0, 32'h10, 32'h0, 32'h12345AF0, 1'b0, 16'd1};
        vecs[11] = '{1'b0, 3'd1, 32'h11, 32'h0, 32'h0, 1'b1, 16'd2};
        vecs[12] = '{1'b0, 3'd6, 32'h10, 32'h0, 32'h0, 1'b1, 16'd3};
        vecs[13] = '{1'b0, 3'd0, 32'(DEPTH*4), 32'h0, 32'h0, 1'b1, 16'd4};
        vecs[14] = '{1'b1, 3'd0, 32'h80000010, 32'h0, 32'h0, 1'b1, 16'd5};
        vecs[15] = '{1'b0, 3'd0, 32'h10, 32'h0, 32'h12345AF0, 1'b0, 16'd5};
        vecs[16] = '{1'b1, 3'd0, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 16'd5};
        vecs[17] = '{1'b0, 3'd0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 16'd5};
        vecs[18] = '{1'b1, 3'd0, 32'h24, 32'hCAFEF00D, 32'h0, 1'b0, 16'd5};

        // reset state
        #12;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // back-to-back table: one request accepted per edge
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].we, vecs[i].typ, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(vecs[i].exp_cnt));
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // backpressure: hold the response for three cycles with a request queued
        drive(1'b0, 3'd0, 32'h10, 32'h0);
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b0, 3'd0, 32'h20, 32'h0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d_req_ready", c), 32'(req_ready), 32'd0);
            chk($sformatf("stall%0d_rsp_valid", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d_rdata", c), rsp_rdata, 32'h12345AF0);
            @(posedge clk);
            #1;
        end
        chk("stall_hold_rdata", rsp_rdata, 32'h12345AF0);
        rsp_ready = 1'b1;
        #1;
        chk("release_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("release_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("release_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("release_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;
        chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);

        // reset with a pending response and a store to 0x24 on the port
        drive(1'b0, 3'd0, 32'h20, 32'h0);
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        drive(1'b1, 3'd0, 32'h24, 32'h11111111);
        rsp_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        chk("post_rst_err_count", 32'(err_count), 32'd0);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        drive(1'b0, 3'd0, 32'h24, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("post_rst_lw24", rsp_rdata, 32'hCAFEF00D);
        chk("post_rst_lw24_err", 32'(rsp_err), 32'd0);

        // signed byte from the top lane of 0xDEADBEEF and unsigned from lane 0
        drive(1'b0, 3'd3, 32'h23, 32'h0);
        @(posedge clk);
        #1;
        chk("lb_0x23", rsp_rdata, 32'hFFFFFFDE);
        drive(1'b0, 3'd4, 32'h20, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("lbu_0x20", rsp_rdata, 32'h000000EF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
